// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_pkg
// Brief   : Shared types and constants for the 9-bit-ISA core.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int DEFAULT_PC_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    // Major opcodes and ALU sub-ops, shared with the decoder
    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_JR   = 3'b011;
    localparam logic [2:0] OP_DONE = 3'b111;

    localparam logic [1:0] SUBOP_ADD  = 2'b00;
    localparam logic [1:0] SUBOP_SUB  = 2'b01;
    localparam logic [1:0] SUBOP_NAND = 2'b10;
    localparam logic [1:0] SUBOP_BEQ  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/next_pc_unit.sv
//------------------------------------------------------------------------------
// Module  : next_pc_unit
// Brief   : Combinational next-PC: relative jump, skip-next, or sequential.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module next_pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_jump,
    input  logic                i_branch_taken,
    input  logic [7:0]          i_imm,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    logic [PC_WIDTH-1:0] w_imm_ext;

    assign w_imm_ext = {{(PC_WIDTH-8){i_imm[7]}}, i_imm};

    // All sums are taken modulo 2^PC_WIDTH, so wrap-around is free
    always_comb begin
        if (i_jump) begin
            o_next_pc = i_pc + w_imm_ext;
        end else if (i_branch_taken) begin
            o_next_pc = i_pc + PC_WIDTH'(2);
        end else begin
            o_next_pc = i_pc + PC_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//------------------------------------------------------------------------------
// Module  : fetch_sequencer
// Brief   : Multi-cycle fetch/execute/memory control FSM owning the core PC.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH  = DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] START_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 ir_load,
    input  logic                 dec_jump,
    input  logic                 dec_branch,
    input  logic [7:0]           dec_imm,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic                 dec_done,
    input  logic                 alu_zero,
    output logic                 commit,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    seq_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ir_load_q, ir_load_d;
    logic                 mem_req_q, mem_req_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;

    logic [PC_WIDTH-1:0]  w_next_pc;
    logic                 w_branch_taken;
    logic                 w_busy_state;

    assign w_branch_taken = dec_branch & alu_zero;
    assign w_busy_state   = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM);

    next_pc_unit #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc (
        .i_pc           (pc_q),
        .i_jump         (dec_jump),
        .i_branch_taken (w_branch_taken),
        .i_imm          (dec_imm),
        .o_next_pc      (w_next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;

        if (w_busy_state && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                // DONE outranks every other decoder flag
                if (dec_done) begin
                    state_d = HALT;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = MEM;
                end else begin
                    commit  = 1'b1;
                    pc_d    = w_next_pc;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    commit  = 1'b1;
                    pc_d    = w_next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Moore outputs are registered from the state being entered
        ir_load_d = (state_d == FETCH);
        mem_req_d = (state_d == MEM);
        busy_d    = (state_d == FETCH) || (state_d == EXEC) || (state_d == MEM);
        halted_d  = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            cnt_q     <= '0;
            ir_load_q <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            ir_load_q <= ir_load_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign ir_load     = ir_load_q;
    assign mem_req     = mem_req_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign cycle_count = cnt_q;

endmodule

`default_nettype wire
